// File: rtl/bcd_countdown_timer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_countdown_timer_pkg: state encoding, BCD constants and preset clamp.
// Revision: 1.0
// ---------------------------------------------------------------------------
package bcd_countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  // Non-BCD preset codes (A-F) saturate to 9 rather than loading garbage.
  function automatic logic [3:0] bcd_clamp(input logic [3:0] x);
    return (x > BCD_MAX) ? BCD_MAX : x;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_countdown_timer_digit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_down_digit: one synchronous BCD down-counter stage, wraps 0 -> 9 with borrow.
// Revision: 1.0
// ---------------------------------------------------------------------------
module bcd_down_digit
  import bcd_countdown_timer_pkg::*;
(
  input  logic       clk,
  input  logic       mr,
  input  logic       load,
  input  logic [3:0] d,
  input  logic       en,
  output logic [3:0] q,
  output logic       bo
);

  logic [3:0] q_d;
  logic [3:0] q_q;

  always_comb begin
    q_d = q_q;
    if (mr) begin
      q_d = BCD_ZERO;
    end else if (load) begin
      q_d = d;
    end else if (en) begin
      q_d = (q_q == BCD_ZERO) ? BCD_MAX : (q_q - 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q  = q_q;
  assign bo = en && (q_q == BCD_ZERO);

endmodule
`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_countdown_timer: two-digit BCD countdown with prescaler, pause and held alarm.
// Revision: 1.0
// ---------------------------------------------------------------------------
module bcd_countdown_timer
  import bcd_countdown_timer_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       mr,
  input  logic       load,
  input  logic [3:0] preset_tens,
  input  logic [3:0] preset_ones,
  input  logic       start,
  input  logic       pause,
  input  logic       ack,
  output logic [3:0] q_tens,
  output logic [3:0] q_ones,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int             PW         = $clog2(DIV);
  localparam logic [PW-1:0]  PRESC_LAST = PW'(DIV - 1);

  state_e        state_d, state_q;
  logic [PW-1:0] presc_d, presc_q;
  logic          done_d, done_q;
  logic          running_q;
  logic          alarm_q;

  logic          step;
  logic          ones_bo;
  logic          tens_bo;
  logic          value_zero;
  logic          last_step;
  logic [3:0]    load_tens;
  logic [3:0]    load_ones;

  assign load_tens  = bcd_clamp(preset_tens);
  assign load_ones  = bcd_clamp(preset_ones);
  assign value_zero = (q_tens == BCD_ZERO) && (q_ones == BCD_ZERO);
  assign last_step  = (q_tens == BCD_ZERO) && (q_ones == 4'd1);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    step    = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
      presc_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && !value_zero) begin
            state_d = ST_RUN;
            presc_d = '0;
          end
        end
        ST_RUN: begin
          // A step on the same edge as pause is taken before the pause.
          if (presc_q == PRESC_LAST) begin
            step    = 1'b1;
            presc_d = '0;
            if (last_step) begin
              state_d = ST_ALARM;
              done_d  = 1'b1;
            end else if (pause) begin
              state_d = ST_PAUSE;
            end
          end else if (pause) begin
            state_d = ST_PAUSE;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (start && !pause) begin
            state_d = ST_RUN;
          end
        end
        ST_ALARM: begin
          if (ack) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mr) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      running_q <= (state_d == ST_RUN);
      alarm_q   <= (state_d == ST_ALARM);
    end
  end

  bcd_down_digit u_ones (
    .clk  (clk),
    .mr   (mr),
    .load (load),
    .d    (load_ones),
    .en   (step),
    .q    (q_ones),
    .bo   (ones_bo)
  );

  // Tens borrow is never used: reaching 00 always leaves RUN first.
  bcd_down_digit u_tens (
    .clk  (clk),
    .mr   (mr),
    .load (load),
    .d    (load_tens),
    .en   (ones_bo),
    .q    (q_tens),
    .bo   (tens_bo)
  );

  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bcd_countdown_timer: scoreboard bench for the two-digit BCD countdown timer.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       mr = 1'b1;
  logic       load = 1'b0;
  logic [3:0] preset_tens = 4'd0;
  logic [3:0] preset_ones = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] q_tens;
  logic [3:0] q_ones;
  logic       running;
  logic       done;
  logic       alarm;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  typedef struct {
    int         cyc;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       run;
    logic       dn;
    logic       alm;
    string      tag;
  } exp_t;

  exp_t sb[$];

  bcd_countdown_timer #(.DIV(4)) dut (
    .clk         (clk),
    .mr          (mr),
    .load        (load),
    .preset_tens (preset_tens),
    .preset_ones (preset_ones),
    .start       (start),
    .pause       (pause),
    .ack         (ack),
    .q_tens      (q_tens),
    .q_ones      (q_ones),
    .running     (running),
    .done        (done),
    .alarm       (alarm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected snapshots are due after a given edge and compared on the falling edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      tests_run++;
      if (e.cyc != cyc || q_tens !== e.tens || q_ones !== e.ones ||
          running !== e.run || done !== e.dn || alarm !== e.alm) begin
        tests_failed++;
        $display("FAIL %s cyc=%0d due=%0d: got q=%h%h run=%b done=%b alarm=%b, want q=%h%h run=%b done=%b alarm=%b",
                 e.tag, cyc, e.cyc, q_tens, q_ones, running, done, alarm,
                 e.tens, e.ones, e.run, e.dn, e.alm);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int off, input logic [3:0] t, input logic [3:0] o,
                           input logic r, input logic d, input logic a, input string tag);
    exp_t e;
    e.cyc  = cyc + off;
    e.tens = t;
    e.ones = o;
    e.run  = r;
    e.dn   = d;
    e.alm  = a;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    tick(2);
    tests_run++;
    if ({q_tens, q_ones} !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_digits: got %h%h want 00", q_tens, q_ones);
    end
    tests_run++;
    if ({running, done, alarm} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got run/done/alarm=%b%b%b want 000", running, done, alarm);
    end
    mr = 1'b0;
    // Reset in the middle of a countdown, with load also asserted.
    preset_tens = 4'd2; preset_ones = 4'd5; load = 1'b1;
    expect_at(1, 4'd2, 4'd5, 0, 0, 0, "mid_load25");
    tick(1); load = 1'b0;
    start = 1'b1;
    expect_at(1, 4'd2, 4'd5, 1, 0, 0, "mid_start");
    expect_at(4, 4'd2, 4'd5, 1, 0, 0, "mid_before_step");
    expect_at(5, 4'd2, 4'd4, 1, 0, 0, "mid_24");
    tick(1); start = 1'b0;
    tick(4);
    mr = 1'b1; load = 1'b1; preset_tens = 4'd7; preset_ones = 4'd7;
    expect_at(1, 4'd0, 4'd0, 0, 0, 0, "mid_reset");
    tick(1); mr = 1'b0; load = 1'b0;
    start = 1'b1;
    expect_at(1, 4'd0, 4'd0, 0, 0, 0, "start_at_00_ignored");
    tick(1); start = 1'b0;
  endtask

  task automatic test_basic();
    preset_tens = 4'd0; preset_ones = 4'd3; load = 1'b1;
    expect_at(1, 4'd0, 4'd3, 0, 0, 0, "basic_load");
    tick(1); load = 1'b0;
    start = 1'b1;
    expect_at(1,  4'd0, 4'd3, 1, 0, 0, "basic_start");
    expect_at(4,  4'd0, 4'd3, 1, 0, 0, "basic_hold03");
    expect_at(5,  4'd0, 4'd2, 1, 0, 0, "basic_02");
    expect_at(8,  4'd0, 4'd2, 1, 0, 0, "basic_hold02");
    expect_at(9,  4'd0, 4'd1, 1, 0, 0, "basic_01");
    expect_at(13, 4'd0, 4'd0, 0, 1, 1, "basic_done");
    expect_at(14, 4'd0, 4'd0, 0, 0, 1, "basic_done_once");
    tick(1); start = 1'b0;
    tick(13);
    tests_run++;
    if (alarm !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_alarm_held: got %b want 1", alarm);
    end
    ack = 1'b1;
    expect_at(1, 4'd0, 4'd0, 0, 0, 0, "basic_ack");
    tick(1); ack = 1'b0;
    expect_at(1, 4'd0, 4'd0, 0, 0, 0, "basic_idle");
    tick(1);
  endtask

  task automatic test_borrow();
    preset_tens = 4'd1; preset_ones = 4'd0; load = 1'b1;
    expect_at(1, 4'd1, 4'd0, 0, 0, 0, "borrow_load");
    tick(1); load = 1'b0;
    start = 1'b1;
    expect_at(1, 4'd1, 4'd0, 1, 0, 0, "borrow_start");
    expect_at(4, 4'd1, 4'd0, 1, 0, 0, "borrow_hold10");
    expect_at(5, 4'd0, 4'd9, 1, 0, 0, "borrow_09");
    tick(1); start = 1'b0;
    tick(4);
    tests_run++;
    if ({q_tens, q_ones} !== 8'h09) begin
      tests_failed++;
      $display("FAIL borrow_inline: got %h%h want 09", q_tens, q_ones);
    end
  endtask

  task automatic test_pause_resume();
    preset_tens = 4'd2; preset_ones = 4'd0; load = 1'b1;
    expect_at(1, 4'd2, 4'd0, 0, 0, 0, "pause_load");
    tick(1); load = 1'b0;
    start = 1'b1;
    expect_at(1, 4'd2, 4'd0, 1, 0, 0, "pause_start");
    expect_at(5, 4'd1, 4'd9, 1, 0, 0, "pause_19");
    expect_at(7, 4'd1, 4'd9, 1, 0, 0, "pause_pre");
    tick(1); start = 1'b0;
    tick(6);
    pause = 1'b1;
    expect_at(1, 4'd1, 4'd9, 0, 0, 0, "pause_enter");
    tick(1); pause = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      tests_run++;
      if ({q_tens, q_ones, running} !== {8'h19, 1'b0}) begin
        tests_failed++;
        $display("FAIL pause_hold%0d: got q=%h%h run=%b want q=19 run=0", i, q_tens, q_ones, running);
      end
    end
    pause = 1'b1; start = 1'b1;
    expect_at(1, 4'd1, 4'd9, 0, 0, 0, "pause_start_together");
    tick(1); pause = 1'b0; start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      tests_run++;
      if ({q_tens, q_ones} !== 8'h19) begin
        tests_failed++;
        $display("FAIL pause_hold_b%0d: got q=%h%h want 19", i, q_tens, q_ones);
      end
    end
    start = 1'b1;
    expect_at(1, 4'd1, 4'd9, 1, 0, 0, "resume_run");
    expect_at(2, 4'd1, 4'd9, 1, 0, 0, "resume_hold");
    expect_at(3, 4'd1, 4'd8, 1, 0, 0, "resume_18");
    tick(1); start = 1'b0;
    tick(2);
  endtask

  task automatic test_edge_cases();
    preset_tens = 4'hF; preset_ones = 4'hA; load = 1'b1;
    expect_at(1, 4'd9, 4'd9, 0, 0, 0, "clamp_FA_99");
    tick(1);
    preset_tens = 4'hC; preset_ones = 4'h3;
    expect_at(1, 4'd9, 4'd3, 0, 0, 0, "clamp_C3_93");
    tick(1);
    preset_tens = 4'd0; preset_ones = 4'd1;
    expect_at(1, 4'd0, 4'd1, 0, 0, 0, "alarm_load01");
    tick(1); load = 1'b0;
    start = 1'b1;
    expect_at(1, 4'd0, 4'd1, 1, 0, 0, "alarm_start");
    expect_at(4, 4'd0, 4'd1, 1, 0, 0, "alarm_hold01");
    expect_at(5, 4'd0, 4'd0, 0, 1, 1, "alarm_done");
    expect_at(6, 4'd0, 4'd0, 0, 0, 1, "alarm_held");
    tick(1); start = 1'b0;
    tick(5);
    start = 1'b1; pause = 1'b1;
    expect_at(1, 4'd0, 4'd0, 0, 0, 1, "alarm_ignores_start_pause");
    tick(1); start = 1'b0; pause = 1'b0;
    preset_tens = 4'd4; preset_ones = 4'd2; load = 1'b1;
    expect_at(1, 4'd4, 4'd2, 0, 0, 0, "alarm_load42");
    tick(1); load = 1'b0;
    start = 1'b1;
    expect_at(1, 4'd4, 4'd2, 1, 0, 0, "ack_run_start");
    tick(1); start = 1'b0;
    ack = 1'b1;
    expect_at(1, 4'd4, 4'd2, 1, 0, 0, "ack_run_1");
    expect_at(2, 4'd4, 4'd2, 1, 0, 0, "ack_run_2");
    expect_at(3, 4'd4, 4'd2, 1, 0, 0, "ack_run_3");
    tick(3); ack = 1'b0;
    expect_at(1, 4'd4, 4'd1, 1, 0, 0, "ack_run_41");
    tick(1);
  endtask

  task automatic test_simultaneous();
    pause = 1'b1; start = 1'b1;
    expect_at(1, 4'd4, 4'd1, 0, 0, 0, "run_pause_start");
    tick(1); pause = 1'b0; start = 1'b0;
    preset_tens = 4'd0; preset_ones = 4'd5; load = 1'b1; start = 1'b1;
    expect_at(1, 4'd0, 4'd5, 0, 0, 0, "load_start");
    tick(1); load = 1'b0; start = 1'b0;
    expect_at(1, 4'd0, 4'd5, 0, 0, 0, "load_start_idle");
    tick(1);
    preset_tens = 4'd0; preset_ones = 4'd1; load = 1'b1;
    expect_at(1, 4'd0, 4'd1, 0, 0, 0, "pstep_load");
    tick(1); load = 1'b0;
    start = 1'b1;
    expect_at(1, 4'd0, 4'd1, 1, 0, 0, "pstep_start");
    tick(1); start = 1'b0;
    expect_at(1, 4'd0, 4'd1, 1, 0, 0, "pstep_w1");
    expect_at(2, 4'd0, 4'd1, 1, 0, 0, "pstep_w2");
    expect_at(3, 4'd0, 4'd1, 1, 0, 0, "pstep_w3");
    tick(3);
    pause = 1'b1;
    expect_at(1, 4'd0, 4'd0, 0, 1, 1, "pause_on_final_step");
    tick(1); pause = 1'b0;
    expect_at(1, 4'd0, 4'd0, 0, 0, 1, "pstep_alarm_held");
    tick(1);
    ack = 1'b1;
    expect_at(1, 4'd0, 4'd0, 0, 0, 0, "pstep_ack");
    tick(1); ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_borrow();
    test_pause_resume();
    test_edge_cases();
    test_simultaneous();
    tick(2);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
